// File: rtl/coin_key_conditioner.sv
// rtl/coin_key_conditioner.sv - key synchronizer/debouncer, coin credit register and ASCII credit digits
//
// Purpose: conditions the four raw active-low pushbuttons (three coins, one
// confirm) into single-cycle press events, accumulates saturating customer
// credit, and presents that credit as two ASCII characters for the LCD.
//
// Ports:
//   iCLK_50MHZ     in   system clock
//   iRST           in   asynchronous active-high reset
//   botao0..2      in   raw coin keys, active-low, asynchronous
//   botao          in   raw confirm key, active-low, asynchronous
//   clr_credit     in   synchronous credit/overflow clear, wins over coins
//   credit         out  current credit, binary
//   credit_tens    out  ASCII tens digit (space or '1')
//   credit_ones    out  ASCII ones digit
//   coin_evt       out  one-cycle pulse when a coin was added to credit
//   confirm_pulse  out  one-cycle pulse per debounced confirm press
//   overflow       out  sticky flag: a coin was rejected by saturation
module coin_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CREDIT_MAX      = 15,
  parameter int COIN0_VAL       = 1,
  parameter int COIN1_VAL       = 2,
  parameter int COIN2_VAL       = 5
) (
  input  logic       iCLK_50MHZ,
  input  logic       iRST,
  input  logic       botao0,
  input  logic       botao1,
  input  logic       botao2,
  input  logic       botao,
  input  logic       clr_credit,
  output logic [3:0] credit,
  output logic [7:0] credit_tens,
  output logic [7:0] credit_ones,
  output logic       coin_evt,
  output logic       confirm_pulse,
  output logic       overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Key order: [0]=botao0, [1]=botao1, [2]=botao2, [3]=confirm.
  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    stable;
  logic [3:0]    press;
  logic [CW-1:0] cnt [4];

  logic [4:0] add;
  logic [4:0] sum;
  logic [3:0] ones_digit;

  assign raw = {botao, botao2, botao1, botao0};

  // A press is recognised on the same edge that stable falls, so the event
  // registers coincide with the debounced transition rather than a cycle later.
  always_comb begin
    press = '0;
    for (int i = 0; i < 4; i++) begin
      press[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST) && !sync2[i];
    end
  end

  always_ff @(posedge iCLK_50MHZ or posedge iRST) begin
    if (iRST) begin
      sync1  <= '1;
      sync2  <= '1;
      stable <= '1;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Simultaneous coins are summed and accepted or rejected as one unit.
  always_comb begin
    add = (press[0] ? 5'(COIN0_VAL) : 5'd0)
        + (press[1] ? 5'(COIN1_VAL) : 5'd0)
        + (press[2] ? 5'(COIN2_VAL) : 5'd0);
    sum = {1'b0, credit} + add;
  end

  always_ff @(posedge iCLK_50MHZ or posedge iRST) begin
    if (iRST) begin
      credit        <= 4'd0;
      coin_evt      <= 1'b0;
      confirm_pulse <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      confirm_pulse <= press[3];
      coin_evt      <= 1'b0;
      if (clr_credit) begin
        credit   <= 4'd0;
        overflow <= 1'b0;
      end else if (add != 5'd0) begin
        if (sum <= 5'(CREDIT_MAX)) begin
          credit   <= sum[3:0];
          coin_evt <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    ones_digit = (credit >= 4'd10) ? (credit - 4'd10) : credit;
  end

  assign credit_tens = (credit >= 4'd10) ? 8'h31 : 8'h20;
  assign credit_ones = 8'h30 + {4'b0000, ones_digit};

endmodule

// File: tb/tb_coin_key_conditioner.sv
// tb/tb_coin_key_conditioner.sv - scoreboard bench for coin_key_conditioner
module tb_coin_key_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       botao0, botao1, botao2, botao;
  logic       clr_credit;
  logic [3:0] credit;
  logic [7:0] credit_tens, credit_ones;
  logic       coin_evt, confirm_pulse, overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic       coin;
    logic       conf;
    logic [3:0] credit;
    logic [7:0] tens;
    logic [7:0] ones;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t sbq[$];

  coin_key_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .iCLK_50MHZ    (clk),
    .iRST          (rst),
    .botao0        (botao0),
    .botao1        (botao1),
    .botao2        (botao2),
    .botao         (botao),
    .clr_credit    (clr_credit),
    .credit        (credit),
    .credit_tens   (credit_tens),
    .credit_ones   (credit_ones),
    .coin_evt      (coin_evt),
    .confirm_pulse (confirm_pulse),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected event lands 6 edges after the edge preceding the input change:
  // the next edge samples the key low, and the event registers 1+4 edges later.
  task automatic expect_evt(input logic coin, input logic conf, input logic [3:0] cr,
                            input logic [7:0] tens, input logic [7:0] ones, input logic ovf);
    exp_t e;
    e.coin = coin; e.conf = conf; e.credit = cr;
    e.tens = tens; e.ones = ones; e.ovf = ovf; e.cyc = cyc + 6;
    sbq.push_back(e);
  endtask

  // Monitor: any output pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && (coin_evt === 1'b1 || confirm_pulse === 1'b1)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_event_queue_size", 32'(sbq.size()), 32'd1);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("evt_coin",    32'(coin_evt),      32'(e.coin));
        chk("evt_confirm", 32'(confirm_pulse), 32'(e.conf));
        chk("evt_credit",  32'(credit),        32'(e.credit));
        chk("evt_tens",    32'(credit_tens),   32'(e.tens));
        chk("evt_ones",    32'(credit_ones),   32'(e.ones));
        chk("evt_ovf",     32'(overflow),      32'(e.ovf));
        chk("evt_cycle",   32'(cyc),           32'(e.cyc));
      end
    end
  end

  task automatic check_state(input string tag, input logic [3:0] cr, input logic [7:0] tens,
                             input logic [7:0] ones, input logic ovf);
    chk({tag, "_credit"}, 32'(credit),      32'(cr));
    chk({tag, "_tens"},   32'(credit_tens), 32'(tens));
    chk({tag, "_ones"},   32'(credit_ones), 32'(ones));
    chk({tag, "_ovf"},    32'(overflow),    32'(ovf));
  endtask

  task automatic pulse_clear();
    clr_credit = 1'b1;
    tick(1);
    clr_credit = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    botao0 = 1'b1; botao1 = 1'b1; botao2 = 1'b1; botao = 1'b1;
    clr_credit = 1'b0;

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #3 rst = 1'b1;
    #1;
    check_state("reset", 4'd0, 8'h20, 8'h30, 1'b0);
    chk("reset_coin_evt", 32'(coin_evt),      32'd0);
    chk("reset_confirm",  32'(confirm_pulse), 32'd0);
    tick(3);
    rst = 1'b0;
    tick(2);

    // Long hold of botao1: exactly one event.
    expect_evt(1'b1, 1'b0, 4'd2, 8'h20, 8'h32, 1'b0);
    botao1 = 1'b0;
    tick(20);
    botao1 = 1'b1;
    tick(10);
    check_state("hold_b1", 4'd2, 8'h20, 8'h32, 1'b0);

    // Short glitches on botao0: no event.
    botao0 = 1'b0; tick(3); botao0 = 1'b1; tick(6);
    botao0 = 1'b0; tick(1); botao0 = 1'b1; tick(1);
    botao0 = 1'b0; tick(1); botao0 = 1'b1; tick(10);
    check_state("glitch", 4'd2, 8'h20, 8'h32, 1'b0);

    pulse_clear();
    check_state("clear1", 4'd0, 8'h20, 8'h30, 1'b0);
    tick(2);

    // Three botao2 presses up to saturation.
    expect_evt(1'b1, 1'b0, 4'd5, 8'h20, 8'h35, 1'b0);
    botao2 = 1'b0; tick(8); botao2 = 1'b1; tick(8);
    expect_evt(1'b1, 1'b0, 4'd10, 8'h31, 8'h30, 1'b0);
    botao2 = 1'b0; tick(8); botao2 = 1'b1; tick(8);
    expect_evt(1'b1, 1'b0, 4'd15, 8'h31, 8'h35, 1'b0);
    botao2 = 1'b0; tick(8); botao2 = 1'b1; tick(8);
    check_state("sat15", 4'd15, 8'h31, 8'h35, 1'b0);

    // One more coin overflows: no event, sticky flag.
    botao0 = 1'b0; tick(8); botao0 = 1'b1; tick(8);
    check_state("overflow", 4'd15, 8'h31, 8'h35, 1'b1);
    tick(3);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    pulse_clear();
    check_state("clear2", 4'd0, 8'h20, 8'h30, 1'b0);
    tick(2);

    // Simultaneous botao0 + botao2: one event, credit 6.
    expect_evt(1'b1, 1'b0, 4'd6, 8'h20, 8'h36, 1'b0);
    botao0 = 1'b0; botao2 = 1'b0;
    tick(8);
    botao0 = 1'b1; botao2 = 1'b1;
    tick(8);
    check_state("dual", 4'd6, 8'h20, 8'h36, 1'b0);

    // botao1 event coincides with clr_credit: coin discarded.
    botao1 = 1'b0;
    tick(5);
    clr_credit = 1'b1;
    tick(1);
    clr_credit = 1'b0;
    chk("clr_vs_coin_evt", 32'(coin_evt), 32'd0);
    check_state("clr_vs_coin", 4'd0, 8'h20, 8'h30, 1'b0);
    tick(4);
    botao1 = 1'b1;
    tick(10);
    check_state("clr_vs_coin_later", 4'd0, 8'h20, 8'h30, 1'b0);

    // Confirm key held: one pulse, credit untouched.
    expect_evt(1'b0, 1'b1, 4'd0, 8'h20, 8'h30, 1'b0);
    botao = 1'b0; tick(15); botao = 1'b1; tick(10);

    // Reset two cycles into a botao0 press; full window restarts on release.
    botao0 = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    expect_evt(1'b1, 1'b0, 4'd1, 8'h20, 8'h31, 1'b0);
    tick(12);
    botao0 = 1'b1;
    tick(10);
    check_state("post_reset", 4'd1, 8'h20, 8'h31, 1'b0);

    chk("pending_events", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/coin_key_conditioner.md
# coin_key_conditioner

Front-end stage for the vending machine: takes the four raw active-low DE2 pushbuttons (three coin keys and the confirm key), synchronizes and debounces them, and turns each press into exactly one single-cycle event. It keeps the customer credit register, which saturates at a maximum, and presents that credit as two ASCII digits ready for the LCD character generator. It feeds the sale FSM and the LCD text table directly, replacing the raw-button counters in those stages.

## Interface
- DEBOUNCE_CYCLES, 1000000, stable-sample count required before a key change is accepted (20 ms at 50 MHz; ≥2)
- CREDIT_MAX, 15, saturation ceiling for credit (≤15)
- COIN0_VAL / COIN1_VAL / COIN2_VAL, 1 / 2 / 5, credit value of botao0 / botao1 / botao2
- iCLK_50MHZ  in  1  system clock; single clock domain
- iRST  in  1  reset, asynchronous, active-high
- botao0, botao1, botao2  in  1  raw coin keys, active-low, asynchronous to clock
- botao  in  1  raw confirm key, active-low
- clr_credit  in  1  synchronous credit clear from sale FSM (vend done / refund)
- credit  out  4  current credit, binary
- credit_tens  out  8  ASCII tens digit: 0x20 if credit<10, else 0x31
- credit_ones  out  8  ASCII ones digit: 0x30 + (credit mod 10)
- coin_evt  out  1  one-cycle pulse: credit accepted a coin this cycle
- confirm_pulse  out  1  one-cycle pulse per debounced confirm press
- overflow  out  1  sticky: a coin was rejected because of saturation

## Operation
- Per key: 2-flop synchronizer (reset value 1) → debouncer holding `stable` (reset 1) and a counter.
- Debouncer: counter clears on any cycle where synced sample == stable. It increments while they differ. When the count reaches DEBOUNCE_CYCLES−1 with the sample still differing, stable takes the sample and the counter clears.
- Press event = stable transitions 1→0. Release (0→1) is debounced but produces no event. A held key produces one event only.
- Coin add: add = sum of values of all coin press events in this cycle (5-bit arithmetic, max 8).
  - If add>0 and credit+add ≤ CREDIT_MAX: credit ← credit+add, coin_evt=1. Simultaneous coins yield one coin_evt.
  - If credit+add > CREDIT_MAX: credit unchanged, coin_evt=0, overflow ← 1.
- clr_credit=1: credit ← 0, overflow ← 0. This has priority over any same-cycle coin, which is discarded (coin_evt=0, no overflow).
- Confirm press event → confirm_pulse=1 for that cycle. It is independent of credit and clear.
- credit_tens and credit_ones are combinational from the credit register.
- Reset values: credit 0, credit_tens 0x20, credit_ones 0x30, coin_evt 0, confirm_pulse 0, overflow 0, all stable=1, all counters 0.
- iRST asserted mid-debounce: partial count is lost. After release, the key must be held a full debounce window again.

## Timing
- Key low from sampling edge N with the level held: the event registers at edge N+1+DEBOUNCE_CYCLES. coin_evt/confirm_pulse are high and credit shows the new value from that edge, for one cycle.
- A low glitch shorter than DEBOUNCE_CYCLES samples produces no event and leaves the counter at 0 afterwards.
- Successive presses require release to be debounced (DEBOUNCE_CYCLES stable high) before the next press counts.
- clr_credit takes effect at the next edge. Credit reads 0 the following cycle.

## Test plan
- Bench uses DEBOUNCE_CYCLES=4 (latency: event 5 edges after the key is first sampled low).
- Reset: assert iRST asynchronously mid-cycle → immediately credit=0, credit_tens=0x20, credit_ones=0x30, coin_evt=0, confirm_pulse=0, overflow=0.
- botao1 held low 20 cycles → exactly one coin_evt, credit=2, ones=0x32; no further pulses while held or on release.
- botao0 low for 3 cycles then high → no coin_evt, credit unchanged; repeat bounce pattern 0-1-0-1 → still no event.
- botao2 pressed three times (with debounced releases) → credit 5, 10 (tens=0x31, ones=0x30), 15 (ones=0x35). A following botao0 press → credit stays 15, coin_evt=0, overflow=1. clr_credit → credit 0, overflow 0.
- botao0 and botao2 pressed on the same cycle → single coin_evt, credit=6. A next press of botao1 with event coinciding with clr_credit → credit=0, coin_evt=0.
- botao held low → one confirm_pulse. iRST pulsed at cycle 2 of a botao0 press, key kept low → event occurs 5 edges after reset release, not before.
